if_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC, the instruction-memory request handshake and the IF/ID pipeline register.

---
 rtl/if_stage.sv | 160 ++++++++++++++++
 tb/tb_if_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request handshake (FETCH/HOLD/KILL) and IF/ID register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
    parameter int                     PC_WIDTH    = 64,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'h0000_0013)
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   pc_load_i,
    input  logic                   if_id_load_i,
    input  logic                   branch_taken_i,
    input  logic [PC_WIDTH-1:0]    branch_target_i,
    output logic                   imem_req_o,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    input  logic                   imem_valid_i,
    output logic [PC_WIDTH-1:0]    if_id_pc_o,
    output logic [INSTR_WIDTH-1:0] if_id_instr_o,
    output logic                   if_id_valid_o,
    output logic                   fetch_busy_o,
    output logic [31:0]            perf_stall_cnt_o,
    output logic [31:0]            perf_flush_cnt_o
);

    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, KILL = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    kill_addr_q, kill_addr_d;
    logic [INSTR_WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic [PC_WIDTH-1:0]    if_id_pc_q, if_id_pc_d;
    logic [INSTR_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
    logic                   if_id_valid_q, if_id_valid_d;
    logic                   req_int;
    logic [PC_WIDTH-1:0]    pc_plus4;

    // A request is outstanding in every state except HOLD; reset masks it.
    assign req_int      = (state_q != HOLD);
    assign imem_req_o   = req_int && !reset_i;
    assign imem_addr_o  = (state_q == KILL) ? kill_addr_q : pc_q;
    assign fetch_busy_o = imem_req_o && !imem_valid_i;
    assign pc_plus4     = pc_q + PC_WIDTH'(4);

    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_valid_o = if_id_valid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_addr_d   = kill_addr_q;
        buf_instr_d   = buf_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (branch_taken_i) begin
            pc_d          = branch_target_i;
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
            // An unanswered request must still be drained; its address stays on the bus.
            if (req_int && !imem_valid_i) begin
                state_d = KILL;
                if (state_q != KILL) kill_addr_d = pc_q;
            end else begin
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_valid_i) begin
                        if (!if_id_load_i) begin
                            buf_instr_d = imem_rdata_i;
                            state_d     = HOLD;
                        end else if (pc_load_i) begin
                            if_id_pc_d    = pc_q;
                            if_id_instr_d = imem_rdata_i;
                            if_id_valid_d = 1'b1;
                            pc_d          = pc_plus4;
                        end else begin
                            if_id_pc_d    = pc_q;
                            if_id_instr_d = NOP_INSTR;
                            if_id_valid_d = 1'b0;
                        end
                    end else if (if_id_load_i) begin
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = NOP_INSTR;
                        if_id_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (if_id_load_i) begin
                        if_id_pc_d = pc_q;
                        if (pc_load_i) begin
                            if_id_instr_d = buf_instr_q;
                            if_id_valid_d = 1'b1;
                            pc_d          = pc_plus4;
                            state_d       = FETCH;
                        end else begin
                            if_id_instr_d = NOP_INSTR;
                            if_id_valid_d = 1'b0;
                        end
                    end
                end
                KILL: begin
                    if (imem_valid_i) state_d = FETCH;
                    if (if_id_load_i) begin
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = NOP_INSTR;
                        if_id_valid_d = 1'b0;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            kill_addr_q   <= '0;
            buf_instr_q   <= NOP_INSTR;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_addr_q   <= kill_addr_d;
            buf_instr_q   <= buf_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_q != KILL && !if_id_load_i) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (branch_taken_i)                   flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`else
    assign perf_stall_cnt_o = '0;
    assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch scenarios followed by random traffic, checked
// every cycle against a transaction-level model of the fetch/IF-ID behaviour.
module tb_if_stage;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef IF_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        pc_load_i = 1'b0, if_id_load_i = 1'b0, branch_taken_i = 1'b0, imem_valid_i = 1'b0;
    logic [63:0] branch_target_i = '0;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_req_o, if_id_valid_o, fetch_busy_o;
    logic [63:0] imem_addr_o, if_id_pc_o;
    logic [31:0] if_id_instr_o, perf_stall_cnt_o, perf_flush_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    if_stage #(.PC_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .pc_load_i(pc_load_i), .if_id_load_i(if_id_load_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
        .imem_valid_i(imem_valid_i), .if_id_pc_o(if_id_pc_o), .if_id_instr_o(if_id_instr_o),
        .if_id_valid_o(if_id_valid_o), .fetch_busy_o(fetch_busy_o),
        .perf_stall_cnt_o(perf_stall_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o));

    always #5 clock_i = ~clock_i;

    // Reference state: what the fetch unit has committed to, not how it encodes it.
    logic [63:0] m_pc = RESET_PC, m_kaddr = '0, m_ifpc = '0;
    logic [31:0] m_hword = '0, m_ifi = NOP, m_stall = '0, m_flush = '0;
    bit          m_have = 0, m_kill = 0, m_ifv = 0;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic put_if(input logic [63:0] pc, input logic [31:0] ins, input bit v);
        m_ifpc = pc; m_ifi = ins; m_ifv = v;
    endtask

    task automatic model_edge(input bit rst, pcl, idl, br, input logic [63:0] tgt,
                              input bit v, input logic [31:0] rd);
        logic [63:0] opc;
        bit          req;
        opc = m_pc;
        req = !m_have;
        if (rst) begin
            m_pc = RESET_PC; m_have = 0; m_kill = 0; m_stall = 0; m_flush = 0;
            put_if(64'h0, NOP, 0);
        end else begin
            if (!m_kill && !idl) m_stall++;
            if (br) begin
                m_flush++;
                if (req && !v) begin
                    if (!m_kill) m_kaddr = opc;
                    m_kill = 1;
                end else m_kill = 0;
                m_pc = tgt; m_have = 0;
                put_if(64'h0, NOP, 0);
            end else if (m_kill) begin
                if (v) m_kill = 0;
                if (idl) put_if(opc, NOP, 0);
            end else if (m_have) begin
                if (idl && pcl) begin
                    put_if(opc, m_hword, 1); m_pc = opc + 64'd4; m_have = 0;
                end else if (idl) put_if(opc, NOP, 0);
            end else if (v) begin
                if (!idl) begin
                    m_have = 1; m_hword = rd;
                end else if (pcl) begin
                    put_if(opc, rd, 1); m_pc = opc + 64'd4;
                end else put_if(opc, NOP, 0);
            end else if (idl) put_if(opc, NOP, 0);
        end
    endtask

    // One clock: drive inputs, check request-side outputs, clock, check registered outputs.
    task automatic step(input bit rst, pcl, idl, br, input logic [63:0] tgt, input bit v);
        bit          exp_req;
        logic [63:0] exp_addr;
        logic [31:0] rd;
        exp_req  = !rst && !m_have;
        exp_addr = m_kill ? m_kaddr : m_pc;
        rd       = mem(exp_addr);
        reset_i = rst; pc_load_i = pcl; if_id_load_i = idl; branch_taken_i = br;
        branch_target_i = tgt; imem_valid_i = v; imem_rdata_i = rd;
        #1;
        chk("imem_req", 64'(imem_req_o), 64'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr_o, exp_addr);
        chk("fetch_busy", 64'(fetch_busy_o), 64'(exp_req && !v));
        @(posedge clock_i);
        #1;
        model_edge(rst, pcl, idl, br, tgt, v, rd);
        chk("if_id_valid", 64'(if_id_valid_o), 64'(m_ifv));
        chk("if_id_instr", 64'(if_id_instr_o), 64'(m_ifi));
        if (m_ifv || br || rst) chk("if_id_pc", if_id_pc_o, m_ifpc);
        chk("perf_stall", 64'(perf_stall_cnt_o), PERF_ON ? 64'(m_stall) : 64'h0);
        chk("perf_flush", 64'(perf_flush_cnt_o), PERF_ON ? 64'(m_flush) : 64'h0);
    endtask

    initial begin
        @(posedge clock_i); #1;
        step(1, 0, 0, 0, 64'h0, 0);
        step(1, 1, 1, 0, 64'h0, 1);
        chk("reset_pc_fetch_addr", imem_addr_o, RESET_PC);
        // Zero-wait streaming: 0,4,8,12.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 0, 64'h0, 1);
            chk("stream_pc", if_id_pc_o, 64'(4 * i));
        end
        // Slow memory at pc=16, then a stalled decode while the next word returns.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 64'h0, 0);
        step(0, 1, 1, 0, 64'h0, 1);
        step(0, 1, 0, 0, 64'h0, 1);
        step(0, 1, 0, 0, 64'h0, 1);
        chk("hold_no_req", 64'(imem_req_o), 64'h0);
        step(0, 1, 1, 0, 64'h0, 1);
        step(0, 1, 1, 0, 64'h0, 1);
        // PC hold bubble, then the same PC delivered.
        step(0, 0, 1, 0, 64'h0, 1);
        step(0, 1, 1, 0, 64'h0, 1);
        // Redirect while a request is pending: old word must never appear.
        step(0, 1, 1, 0, 64'h0, 0);
        step(0, 1, 1, 1, 64'h100, 0);
        step(0, 1, 1, 0, 64'h0, 0);
        step(0, 1, 1, 1, 64'h200, 0);
        step(0, 1, 1, 0, 64'h0, 1);
        step(0, 1, 1, 0, 64'h0, 1);
        chk("redirect_pc", if_id_pc_o, 64'h200);
        // PC wrap-around at the top of the address space.
        step(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        step(0, 1, 1, 0, 64'h0, 1);
        step(0, 1, 1, 0, 64'h0, 1);
        chk("wrap_pc", if_id_pc_o, 64'h0);
        // Reset arriving while a word is held.
        step(0, 1, 0, 0, 64'h0, 1);
        step(0, 1, 0, 0, 64'h0, 1);
        step(1, 1, 0, 0, 64'h0, 1);
        step(0, 1, 1, 0, 64'h0, 1);
        chk("after_reset_addr", imem_addr_o, RESET_PC + 64'd4);
        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [63:0] tgt;
            case ($urandom_range(0, 3))
                0:       tgt = {$urandom, $urandom} & ~64'h3;
                1:       tgt = 64'hFFFF_FFFF_FFFF_FFF8;
                default: tgt = 64'($urandom_range(0, 1023)) << 2;
            endcase
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) == 0, tgt, $urandom_range(0, 9) < 7);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
